// File: rtl/word_join.sv
// Reassembles a serial byte stream into MSB-first words held in a small output FIFO.
// Latency: last byte to out_valid is 1 clock; word_out always shows the FIFO head.
// Backpressure: in_ready drops only for a completing byte while the FIFO is full, or during clear.
module word_join #(
  parameter int WORD_IN_SIZE  = 8,
  parameter int WORD_OUT_SIZE = 32,
  parameter int FIFO_DEPTH    = 2,
  localparam int BYTES = WORD_OUT_SIZE / WORD_IN_SIZE,
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1,
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int LW    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WORD_IN_SIZE-1:0]  data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clear,
  output logic [WORD_OUT_SIZE-1:0] word_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BCW-1:0]           byte_count,
  output logic [LW-1:0]            fifo_level
);

  logic [WORD_OUT_SIZE-1:0] assembly;
  logic [WORD_OUT_SIZE-1:0] full_word;
  logic [WORD_OUT_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic                     last_byte;
  logic                     fifo_full;
  logic                     accept;
  logic                     push;
  logic                     pop;

  assign last_byte = (byte_count == BCW'(BYTES - 1));
  assign fifo_full = (fifo_level == LW'(FIFO_DEPTH));
  // Only registered state feeds in_ready (plus clear), so a same-cycle pop cannot open a full FIFO.
  assign in_ready  = !clear && (!last_byte || !fifo_full);
  assign accept    = in_valid && in_ready;
  assign push      = accept && last_byte;
  assign out_valid = (fifo_level != '0);
  assign pop       = out_valid && out_ready;
  assign full_word = {assembly[WORD_OUT_SIZE-WORD_IN_SIZE-1:0], data_in};
  assign word_out  = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      assembly   <= '0;
      byte_count <= '0;
    end else if (clear) begin
      assembly   <= '0;
      byte_count <= '0;
    end else if (accept) begin
      assembly   <= full_word;
      byte_count <= last_byte ? '0 : byte_count + BCW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= full_word;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

endmodule

// File: tb/tb_word_join.sv
// Bench for word_join: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue-based model of bytes and stored words.
module tb_word_join;
  localparam int BYTES = 4;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        clear = 1'b0;
  logic [31:0] word_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  byte_count;
  logic [1:0]  fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  logic [7:0]  part[$];
  logic [31:0] q[$];

  word_join #(.WORD_IN_SIZE(8), .WORD_OUT_SIZE(32), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .word_out(word_out), .out_valid(out_valid),
    .out_ready(out_ready), .byte_count(byte_count), .fifo_level(fifo_level)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_in_ready();
    return !clear && ((part.size() != BYTES - 1) || (q.size() != DEPTH));
  endfunction

  // Model update for one rising edge, using the inputs held across that edge.
  task automatic model_step();
    bit acc;
    bit pp;
    logic [31:0] w;
    acc = in_valid && model_in_ready();
    pp  = (q.size() != 0) && out_ready;
    if (pp) void'(q.pop_front());
    if (clear) part.delete();
    else if (acc) begin
      part.push_back(data_in);
      if (part.size() == BYTES) begin
        w = 0;
        foreach (part[i]) w = (w << 8) | 32'(part[i]);
        q.push_back(w);
        part.delete();
      end
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      check("in_ready", 32'(in_ready), 32'(model_in_ready()));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("byte_count", 32'(byte_count), 32'(part.size()));
      check("fifo_level", 32'(fifo_level), 32'(q.size()));
      if (q.size() != 0) check("word_out", word_out, q[0]);
    end
  end

  task automatic drive(input bit v, input logic [7:0] d, input bit c, input bit r);
    in_valid = v; data_in = d; clear = c; out_ready = r;
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic reset_pulse();
    check_en = 1'b0;
    drive(0, 8'h00, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_word_out", word_out, 32'h0);
    check("rst_fifo_level", 32'(fifo_level), 32'(0));
    check("rst_byte_count", 32'(byte_count), 32'(0));
    part.delete();
    q.delete();
    @(negedge clock) reset = 1'b1;
    #1 check("rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clock);
    #1 check_en = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    check("init_out_valid", 32'(out_valid), 32'(0));
    check("init_word_out", word_out, 32'h0);
    check("init_in_ready", 32'(in_ready), 32'(1));
    @(negedge clock) reset = 1'b1;
    @(posedge clock);
    #1 check_en = 1'b1;

    // DEADBEEF with consumer ready
    drive(1, 8'hDE, 0, 1); step(); check("t1_bc1", 32'(byte_count), 32'(1));
    drive(1, 8'hAD, 0, 1); step(); check("t1_bc2", 32'(byte_count), 32'(2));
    drive(1, 8'hBE, 0, 1); step(); check("t1_bc3", 32'(byte_count), 32'(3));
    drive(1, 8'hEF, 0, 1); step();
    check("t1_bc0", 32'(byte_count), 32'(0));
    check("t1_valid", 32'(out_valid), 32'(1));
    check("t1_word", word_out, 32'hDEADBEEF);
    drive(0, 8'h00, 0, 1); step();
    check("t1_level0", 32'(fifo_level), 32'(0));

    // Fill the FIFO, then stall on the completing byte
    for (int b = 0; b < 11; b++) begin
      drive(1, 8'(b), 0, 0); step();
    end
    check("t2_level2", 32'(fifo_level), 32'(2));
    check("t2_bc3", 32'(byte_count), 32'(3));
    check("t2_head", word_out, 32'h00010203);
    drive(1, 8'h0B, 0, 0); #1;
    check("t2_stall_rdy", 32'(in_ready), 32'(0));
    step();
    drive(1, 8'h0B, 0, 1); #1;
    check("t2_pop_no_open", 32'(in_ready), 32'(0));
    step();
    check("t2_head2", word_out, 32'h04050607);
    check("t2_bc_still3", 32'(byte_count), 32'(3));
    drive(1, 8'h0B, 0, 1); step();
    check("t2_head3", word_out, 32'h08090A0B);
    check("t2_level1", 32'(fifo_level), 32'(1));
    drive(0, 8'h00, 0, 1); step();

    // Clear discards partial word and the byte presented with it
    drive(1, 8'h11, 0, 1); step();
    drive(1, 8'h22, 0, 1); step();
    drive(1, 8'h33, 1, 1); #1;
    check("t4_clr_rdy", 32'(in_ready), 32'(0));
    step();
    check("t4_bc0", 32'(byte_count), 32'(0));
    drive(1, 8'hA1, 0, 1); step();
    drive(1, 8'hA2, 0, 1); step();
    drive(1, 8'hA3, 0, 1); step();
    drive(1, 8'hA4, 0, 1); step();
    check("t4_word", word_out, 32'hA1A2A3A4);
    drive(0, 8'h00, 0, 1); step();

    // Push and pop on the same edge at level 1
    for (int b = 0; b < 4; b++) begin
      drive(1, 8'h50 + 8'(b), 0, 0); step();
    end
    for (int b = 0; b < 4; b++) begin
      drive(1, 8'h60 + 8'(b), 0, b == 3); step();
    end
    check("t5_level1", 32'(fifo_level), 32'(1));
    check("t5_head", word_out, 32'h60616263);
    drive(0, 8'h00, 0, 1); step();

    // Continuous streaming, 8 words
    for (int b = 0; b < 32; b++) begin
      drive(1, 8'($urandom), 0, 1); #1;
      check("t3_in_ready", 32'(in_ready), 32'(1));
      step();
      check("t3_level_le1", 32'(fifo_level <= 2'd1), 32'(1));
    end
    drive(0, 8'h00, 0, 1); step();

    // Reset mid-word with a full FIFO
    for (int b = 0; b < 10; b++) begin
      drive(1, 8'h80 + 8'(b), 0, 0); step();
    end
    check("t6_level2", 32'(fifo_level), 32'(2));
    reset_pulse();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 19) == 0,
            1'($urandom_range(0, 1)));
      step();
      if (i == 700) reset_pulse();
    end

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
